// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit : RV32I hazard detection, operand forwarding and load-use stall
// Revision    : 1.0
// ============================================================================
module hazard_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs1use_ID,
   input  logic       rs2use_ID,
   input  logic [1:0] hazard_optype_ID,
   input  logic [4:0] rd_ID,
   input  logic [4:0] rs1_ID,
   input  logic [4:0] rs2_ID,
   input  logic       Branch_ID,
   output logic       PC_EN_IF,
   output logic       reg_FD_EN,
   output logic       reg_FD_flush,
   output logic       reg_DE_flush,
   output logic [1:0] forward_ctrl_A,
   output logic [1:0] forward_ctrl_B,
   output logic       forward_ctrl_ls
);

   localparam logic [1:0] c_OP_OTHER = 2'b00;
   localparam logic [1:0] c_OP_ALU   = 2'b01;
   localparam logic [1:0] c_OP_LOAD  = 2'b10;
   localparam logic [1:0] c_OP_STORE = 2'b11;

   // Shadow slots for EX and MEM. A WB slot would carry nothing observable:
   // the load-to-store path is fully described by the ls bit riding in MEM.
   logic [1:0] ex_op_q,  ex_op_d;
   logic [4:0] ex_rd_q,  ex_rd_d;
   logic       ex_ls_q,  ex_ls_d;
   logic [1:0] mem_op_q;
   logic [4:0] mem_rd_q;
   logic       mem_ls_q;

   logic w_ex_wr, w_mem_wr, w_ex_ld;
   logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
   logic w_ls_id, w_stall;

   function automatic logic [1:0] fwd_sel(input logic       ex_hit,
                                          input logic [1:0] ex_op,
                                          input logic       mem_hit,
                                          input logic [1:0] mem_op);
      logic [1:0] sel;
      sel = 2'b00;
      if (ex_hit) begin
         // A hit on an EX load yields the regfile select; stall or ls covers it.
         sel = (ex_op == c_OP_ALU) ? 2'b01 : 2'b00;
      end else if (mem_hit && mem_op == c_OP_ALU) begin
         sel = 2'b10;
      end else if (mem_hit && mem_op == c_OP_LOAD) begin
         sel = 2'b11;
      end
      return sel;
   endfunction

   always_comb begin
      w_ex_wr  = (ex_op_q  == c_OP_ALU || ex_op_q  == c_OP_LOAD) && (ex_rd_q  != 5'd0);
      w_mem_wr = (mem_op_q == c_OP_ALU || mem_op_q == c_OP_LOAD) && (mem_rd_q != 5'd0);
      w_ex_ld  = (ex_op_q == c_OP_LOAD);
      w_ex_m1  = rs1use_ID && w_ex_wr  && (ex_rd_q  == rs1_ID);
      w_ex_m2  = rs2use_ID && w_ex_wr  && (ex_rd_q  == rs2_ID);
      w_mem_m1 = rs1use_ID && w_mem_wr && (mem_rd_q == rs1_ID);
      w_mem_m2 = rs2use_ID && w_mem_wr && (mem_rd_q == rs2_ID);
      w_ls_id  = (hazard_optype_ID == c_OP_STORE) && w_ex_m2 && w_ex_ld
                 && !(w_ex_m1 && w_ex_ld);
      w_stall  = (w_ex_m1 && w_ex_ld) || (w_ex_m2 && w_ex_ld && !w_ls_id);
   end

   always_comb begin
      ex_op_d = c_OP_OTHER;
      ex_rd_d = 5'd0;
      ex_ls_d = 1'b0;
      if (!w_stall) begin
         ex_op_d = hazard_optype_ID;
         ex_rd_d = rd_ID;
         ex_ls_d = w_ls_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_op_q  <= c_OP_OTHER;
         ex_rd_q  <= 5'd0;
         ex_ls_q  <= 1'b0;
         mem_op_q <= c_OP_OTHER;
         mem_rd_q <= 5'd0;
         mem_ls_q <= 1'b0;
      end else begin
         ex_op_q  <= ex_op_d;
         ex_rd_q  <= ex_rd_d;
         ex_ls_q  <= ex_ls_d;
         mem_op_q <= ex_op_q;
         mem_rd_q <= ex_rd_q;
         mem_ls_q <= ex_ls_q;
      end
   end

   assign forward_ctrl_A  = fwd_sel(w_ex_m1, ex_op_q, w_mem_m1, mem_op_q);
   assign forward_ctrl_B  = fwd_sel(w_ex_m2, ex_op_q, w_mem_m2, mem_op_q);
   assign forward_ctrl_ls = mem_ls_q;
   assign PC_EN_IF        = !w_stall;
   assign reg_FD_EN       = !w_stall;
   assign reg_DE_flush    = w_stall;
   // Stall beats branch: branch operands are not valid until the bubble passes.
   assign reg_FD_flush    = Branch_ID && !w_stall;

endmodule
`default_nettype wire
